// File: rtl/rst_seq_gen.sv
// ============================================================================
//  Module      : rst_seq_gen
//  Description : Reset sequencer that holds o_rst_n low for HOLD_CYCLES after
//                the last reset cause, with a saturating release counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rst_seq_gen #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_rst_req,
    input  logic       i_sw_rst,
    output logic       o_rst_n,
    output logic       o_rst_done,
    output logic [7:0] o_rst_cnt
);

    typedef enum logic [0:0] {
        ST_ASSERT = 1'b0,
        ST_RUN    = 1'b1
    } state_t;

    localparam logic [7:0] c_hold_last = 8'(HOLD_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_hcnt;
    logic [7:0] w_hcnt_nxt;
    logic       r_req_meta;
    logic       r_req_s;
    logic       w_cause;
    logic       w_rst_n_nxt;
    logic       w_done_nxt;
    logic [7:0] w_cnt_nxt;

    // Two-flop synchronizer; only r_req_s is used by the sequencer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_meta <= 1'b0;
            r_req_s    <= 1'b0;
        end else begin
            r_req_meta <= i_rst_req;
            r_req_s    <= r_req_meta;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_ASSERT;
            r_hcnt     <= 8'd0;
            o_rst_n    <= 1'b0;
            o_rst_done <= 1'b0;
            o_rst_cnt  <= 8'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_hcnt     <= w_hcnt_nxt;
            o_rst_n    <= w_rst_n_nxt;
            o_rst_done <= w_done_nxt;
            o_rst_cnt  <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_cause     = r_req_s | i_sw_rst;
        w_state_nxt = r_state;
        w_hcnt_nxt  = r_hcnt;
        w_rst_n_nxt = 1'b0;
        w_done_nxt  = 1'b0;
        w_cnt_nxt   = o_rst_cnt;

        case (r_state)
            ST_ASSERT: begin
                // A restart cause always beats a coincident release.
                if (w_cause) begin
                    w_hcnt_nxt = 8'd0;
                end else if (r_hcnt == c_hold_last) begin
                    w_state_nxt = ST_RUN;
                    w_rst_n_nxt = 1'b1;
                    w_done_nxt  = 1'b1;
                    if (o_rst_cnt != 8'hFF) begin
                        w_cnt_nxt = o_rst_cnt + 8'd1;
                    end
                end else begin
                    w_hcnt_nxt = r_hcnt + 8'd1;
                end
            end
            ST_RUN: begin
                w_rst_n_nxt = 1'b1;
                if (w_cause) begin
                    w_state_nxt = ST_ASSERT;
                    w_hcnt_nxt  = 8'd0;
                    w_rst_n_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_ASSERT;
                w_hcnt_nxt  = 8'd0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_rst_seq_gen.sv
// ============================================================================
//  Module      : tb_rst_seq_gen
//  Description : Self-checking bench for rst_seq_gen against a behavioural
//                "edges since last reset cause" model.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rst_seq_gen;

    localparam int HOLD = 16;

    logic       clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_rst_req = 1'b0;
    logic       i_sw_rst = 1'b0;
    logic       o_rst_n;
    logic       o_rst_done;
    logic [7:0] o_rst_cnt;

    always #5 clk = ~clk;

    rst_seq_gen #(.HOLD_CYCLES(HOLD)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_rst_req  (i_rst_req),
        .i_sw_rst   (i_sw_rst),
        .o_rst_n    (o_rst_n),
        .o_rst_done (o_rst_done),
        .o_rst_cnt  (o_rst_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference: output is released once HOLD edges have passed with no cause.
    bit m_valid    = 1'b0;
    int m_since    = 0;
    int m_releases = 0;
    bit m_rst_n    = 1'b0;
    bit m_done     = 1'b0;
    bit m_req_q[$];

    always @(posedge clk) begin
        bit req_s;
        bit cause;
        if (i_rst) begin
            m_valid    = 1'b1;
            m_since    = 0;
            m_releases = 0;
            m_rst_n    = 1'b0;
            m_done     = 1'b0;
            m_req_q    = '{1'b0, 1'b0};
        end else if (m_valid) begin
            m_req_q.push_front(i_rst_req);
            req_s = m_req_q.pop_back();
            cause = req_s || i_sw_rst;
            if (cause) m_since = 0;
            else if (m_since < 1000000) m_since++;
            m_rst_n = (m_since >= HOLD);
            m_done  = (m_since == HOLD);
            if (m_done) m_releases++;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_rst_n", {31'd0, o_rst_n}, {31'd0, m_rst_n});
            check("model_done",  {31'd0, o_rst_done}, {31'd0, m_done});
            check("model_cnt",   {24'd0, o_rst_cnt}, (m_releases > 255) ? 32'd255 : 32'(m_releases));
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic async_set_req(input logic v);
        @(negedge clk);
        #($urandom_range(1, 4));
        i_rst_req = v;
    endtask

    initial begin
        // Test 1: power-on release
        edges(3);
        check("reset_rst_n", {31'd0, o_rst_n}, 32'd0);
        check("reset_done",  {31'd0, o_rst_done}, 32'd0);
        check("reset_cnt",   {24'd0, o_rst_cnt}, 32'd0);
        @(negedge clk) i_rst = 1'b0;
        edges(15);
        check("t1_hold_edge15", {31'd0, o_rst_n}, 32'd0);
        edges(1);
        check("t1_rel_rst_n", {31'd0, o_rst_n}, 32'd1);
        check("t1_rel_done",  {31'd0, o_rst_done}, 32'd1);
        check("t1_rel_cnt",   {24'd0, o_rst_cnt}, 32'd1);
        edges(1);
        check("t1_done_pulse", {31'd0, o_rst_done}, 32'd0);

        // Test 2: software reset in run
        @(negedge clk) i_sw_rst = 1'b1;
        edges(1);
        check("t2_fall", {31'd0, o_rst_n}, 32'd0);
        @(negedge clk) i_sw_rst = 1'b0;
        edges(15);
        check("t2_hold", {31'd0, o_rst_n}, 32'd0);
        edges(1);
        check("t2_rel", {31'd0, o_rst_n}, 32'd1);
        check("t2_cnt", {24'd0, o_rst_cnt}, 32'd2);

        // Test 3: asynchronous request for 5 sampled cycles
        edges(5);
        async_set_req(1'b1);
        edges(2);
        check("t3_pre_fall", {31'd0, o_rst_n}, 32'd1);
        edges(1);
        check("t3_fall", {31'd0, o_rst_n}, 32'd0);
        edges(2);
        async_set_req(1'b0);
        edges(17);
        check("t3_hold", {31'd0, o_rst_n}, 32'd0);
        edges(1);
        check("t3_rel", {31'd0, o_rst_n}, 32'd1);
        check("t3_cnt", {24'd0, o_rst_cnt}, 32'd3);

        // Test 4: restart coinciding with the release condition
        @(negedge clk) i_sw_rst = 1'b1;
        edges(1);
        @(negedge clk) i_sw_rst = 1'b0;
        edges(15);
        @(negedge clk) i_sw_rst = 1'b1;
        edges(1);
        check("t4_no_done", {31'd0, o_rst_done}, 32'd0);
        check("t4_no_rel",  {31'd0, o_rst_n}, 32'd0);
        @(negedge clk) i_sw_rst = 1'b0;
        edges(15);
        check("t4_hold", {31'd0, o_rst_n}, 32'd0);
        edges(1);
        check("t4_rel",  {31'd0, o_rst_n}, 32'd1);
        check("t4_done", {31'd0, o_rst_done}, 32'd1);
        check("t4_cnt",  {24'd0, o_rst_cnt}, 32'd4);

        // Test 6: i_rst mid-hold
        @(negedge clk) i_rst = 1'b1;
        edges(1);
        @(negedge clk) i_rst = 1'b0;
        edges(7);
        @(negedge clk) i_rst = 1'b1;
        edges(1);
        check("t6_rst_n", {31'd0, o_rst_n}, 32'd0);
        check("t6_cnt",   {24'd0, o_rst_cnt}, 32'd0);
        @(negedge clk) i_rst = 1'b0;
        edges(15);
        check("t6_hold", {31'd0, o_rst_n}, 32'd0);
        edges(1);
        check("t6_rel", {31'd0, o_rst_n}, 32'd1);
        check("t6_cnt_rel", {24'd0, o_rst_cnt}, 32'd1);

        // Test 5: release counter saturation
        repeat (260) begin
            @(negedge clk) i_sw_rst = 1'b1;
            edges(1);
            @(negedge clk) i_sw_rst = 1'b0;
            edges(16);
        end
        check("t5_sat", {24'd0, o_rst_cnt}, 32'd255);
        @(negedge clk) i_rst = 1'b1;
        edges(1);
        check("t5_clr_cnt",   {24'd0, o_rst_cnt}, 32'd0);
        check("t5_clr_rst_n", {31'd0, o_rst_n}, 32'd0);
        @(negedge clk) i_rst = 1'b0;
        edges(20);

        // Request held high keeps the downstream stage in reset
        async_set_req(1'b1);
        edges(300);
        check("req_held", {31'd0, o_rst_n}, 32'd0);
        async_set_req(1'b0);
        edges(25);

        // Randomized traffic, checked every cycle by the model
        repeat (3000) begin
            @(negedge clk);
            i_sw_rst = ($urandom_range(0, 39) == 0);
            i_rst    = ($urandom_range(0, 299) == 0);
            if (i_rst_req ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0)) begin
                #($urandom_range(1, 4));
                i_rst_req = ~i_rst_req;
            end
        end
        @(negedge clk);
        i_sw_rst  = 1'b0;
        i_rst     = 1'b0;
        i_rst_req = 1'b0;
        edges(25);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
